// File: rtl/branch_history_table.sv
// Bimodal conditional-branch predictor: 2-bit saturating counters read with the fetch PC,
// prediction registered into decode, trained on the decode-stage resolution.
module branch_history_table #(
  parameter int unsigned INDEX_W  = 6,
  parameter logic [1:0]  INIT_CNT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        is_branchD,
  input  logic        branch_takeD,
  output logic        pred_takeD,
  output logic        mispredictD,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int unsigned ENTRIES = 1 << INDEX_W;

  logic [ENTRIES-1:0][1:0] pht_q, pht_d;
  logic [INDEX_W-1:0]      idxF;
  logic [INDEX_W-1:0]      idx_q, idx_d;
  logic                    pred_q, pred_d;
  logic                    predF;
  logic                    upd;
  logic [31:0]             branch_cnt_q, branch_cnt_d;
  logic [31:0]             mispred_cnt_q, mispred_cnt_d;
  logic                    unused_pc_bits;

  assign idxF           = pcF[INDEX_W+1:2];
  assign predF          = pht_q[idxF][1];
  assign unused_pc_bits = ^{pcF[31:INDEX_W+2], pcF[1:0]};

  assign mispredictD = is_branchD & (pred_q != branch_takeD);
  assign upd         = is_branchD & ~stallD & ~flushD & ~rst;

  // Fetch reads pht_q directly, so a same-index write this cycle is not bypassed.
  always_comb begin
    pht_d = pht_q;
    if (upd) begin
      if (branch_takeD) begin
        if (pht_q[idx_q] != 2'b11) pht_d[idx_q] = pht_q[idx_q] + 2'b01;
      end else begin
        if (pht_q[idx_q] != 2'b00) pht_d[idx_q] = pht_q[idx_q] - 2'b01;
      end
    end
  end

  always_comb begin
    pred_d = pred_q;
    idx_d  = idx_q;
    if (flushD) begin
      pred_d = 1'b0;
      idx_d  = '0;
    end else if (!stallD) begin
      pred_d = predF;
      idx_d  = idxF;
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
      if (mispredictD) mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pht_q         <= {ENTRIES{INIT_CNT}};
      pred_q        <= 1'b0;
      idx_q         <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      pht_q         <= pht_d;
      pred_q        <= pred_d;
      idx_q         <= idx_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign pred_takeD  = pred_q;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_history_table.sv
// Randomized bench for branch_history_table against a behavioural model, with directed
// scenarios carrying hand-computed expectations.
module tb_branch_history_table;

  localparam int unsigned IW = 6;
  localparam int unsigned N  = 1 << IW;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pcF = '0;
  logic        stallD = 1'b0;
  logic        flushD = 1'b0;
  logic        is_branchD = 1'b0;
  logic        branch_takeD = 1'b0;
  logic        pred_takeD;
  logic        mispredictD;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  always #5 clk = ~clk;

  branch_history_table #(.INDEX_W(IW), .INIT_CNT(2'b01)) dut (
    .clk          (clk),
    .rst          (rst),
    .pcF          (pcF),
    .stallD       (stallD),
    .flushD       (flushD),
    .is_branchD   (is_branchD),
    .branch_takeD (branch_takeD),
    .pred_takeD   (pred_takeD),
    .mispredictD  (mispredictD),
    .branch_cnt   (branch_cnt),
    .mispred_cnt  (mispred_cnt)
  );

  int unsigned passed = 0;
  int unsigned total  = 0;

  // Model state: counter strength per entry as plain integers 0..3.
  int          m_cnt [N];
  bit          m_pred  = 1'b0;
  int unsigned m_idx   = 0;
  bit [31:0]   m_bc    = '0;
  bit [31:0]   m_mc    = '0;
  bit          m_valid = 1'b0;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc / 4) % N;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin : model
    bit pf;
    pf = (m_cnt[idx_of(pcF)] >= 2);
    if (rst) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 1;
      m_pred  = 1'b0;
      m_idx   = 0;
      m_bc    = '0;
      m_mc    = '0;
      m_valid = 1'b1;
    end else begin
      if (is_branchD && !stallD && !flushD) begin
        m_bc = m_bc + 1;
        if (m_pred != branch_takeD) m_mc = m_mc + 1;
        if (branch_takeD) m_cnt[m_idx] = (m_cnt[m_idx] == 3) ? 3 : m_cnt[m_idx] + 1;
        else              m_cnt[m_idx] = (m_cnt[m_idx] == 0) ? 0 : m_cnt[m_idx] - 1;
      end
      if (flushD) begin
        m_pred = 1'b0;
        m_idx  = 0;
      end else if (!stallD) begin
        m_pred = pf;
        m_idx  = idx_of(pcF);
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("pred_takeD", {31'd0, pred_takeD}, {31'd0, m_pred});
      chk("mispredictD", {31'd0, mispredictD},
          {31'd0, (is_branchD && (m_pred != branch_takeD))});
      chk("branch_cnt", branch_cnt, m_bc);
      chk("mispred_cnt", mispred_cnt, m_mc);
    end
  end

  task automatic drv(input logic r, input logic [31:0] pc, input logic br, input logic tk,
                     input logic st, input logic fl);
    @(negedge clk);
    #1;
    rst = r; pcF = pc; is_branchD = br; branch_takeD = tk; stallD = st; flushD = fl;
    #1;
  endtask

  task automatic reset_dut();
    drv(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Scenario: not-taken on a weak entry after reset
    reset_dut();
    chk("rst pred", {31'd0, pred_takeD}, 32'd0);
    chk("rst bcnt", branch_cnt, 32'd0);
    chk("rst mcnt", mispred_cnt, 32'd0);
    drv(1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("s1 pred", {31'd0, pred_takeD}, 32'd0);
    chk("s1 mis", {31'd0, mispredictD}, 32'd0);
    drv(1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s1 bcnt", branch_cnt, 32'd1);
    chk("s1 mcnt", mispred_cnt, 32'd0);

    // Scenario: taken training, no bypass, saturation
    reset_dut();
    drv(1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("s2 pred0", {31'd0, pred_takeD}, 32'd0);
    chk("s2 mis0", {31'd0, mispredictD}, 32'd1);
    drv(1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s2 nobypass", {31'd0, pred_takeD}, 32'd0);
    chk("s2 mcnt1", mispred_cnt, 32'd1);
    drv(1'b0, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("s2 pred1", {31'd0, pred_takeD}, 32'd1);
    chk("s2 mis1", {31'd0, mispredictD}, 32'd0);
    drv(1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s2 bcnt", branch_cnt, 32'd2);
    for (int i = 0; i < 4; i++) drv(1'b0, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0);
    drv(1'b0, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sat mis", {31'd0, mispredictD}, 32'd1);
    drv(1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat pred", {31'd0, pred_takeD}, 32'd1);
    chk("sat bcnt", branch_cnt, 32'd7);
    chk("sat mcnt", mispred_cnt, 32'd2);

    // Scenario: stalled branch trains once; flush suppresses update
    drv(1'b0, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drv(1'b0, 32'h80, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("stall pred", {31'd0, pred_takeD}, 32'd0);
      chk("stall mis", {31'd0, mispredictD}, 32'd1);
    end
    drv(1'b0, 32'h80, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("stall bcnt", branch_cnt, 32'd7);
    drv(1'b0, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rel bcnt", branch_cnt, 32'd8);
    chk("rel mcnt", mispred_cnt, 32'd3);
    drv(1'b0, 32'h80, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("fl pred", {31'd0, pred_takeD}, 32'd1);
    drv(1'b0, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fl pred0", {31'd0, pred_takeD}, 32'd0);
    chk("fl bcnt", branch_cnt, 32'd8);
    drv(1'b0, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fl pred1", {31'd0, pred_takeD}, 32'd1);

    // Random traffic on a handful of aliasing indices
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pc;
      pc = ($urandom & ~32'h0000_00FC) | ($urandom_range(0, 7) << 2);
      drv(($urandom_range(0, 99) < 2), pc, $urandom_range(0, 1), $urandom_range(0, 1),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
    end
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/branch_history_table.md
# branch_history_table

Dynamic conditional-branch direction predictor for the 5-stage MIPS pipeline. It reads a table of 2-bit saturating counters with the fetch PC and registers the prediction into the decode stage alongside the instruction. It then compares that prediction against the decode-stage branch resolution result, flags mispredictions, and trains the table on the same clock edge. It also keeps 32-bit branch and misprediction event counters for performance analysis.

## Interface
- INDEX_W, 6, table index width; table holds 2^INDEX_W counters, indexed by pcF[INDEX_W+1:2]
- INIT_CNT, 2'b01, counter value loaded into every entry on reset (weakly not-taken)

- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- pcF  input  32  fetch-stage PC
- stallD  input  1  decode stage stalled; D-stage registers hold
- flushD  input  1  decode stage flushed; D-stage registers cleared
- is_branchD  input  1  instruction in D is a conditional branch: beq, bne, bgtz, blez, bltz, bgez, bltzal, bgezal
- branch_takeD  input  1  resolved direction of the D-stage branch
- pred_takeD  output  1  registered prediction for the instruction in D
- mispredictD  output  1  is_branchD & (pred_takeD != branch_takeD), combinational
- branch_cnt  output  32  number of conditional branches retired from D
- mispred_cnt  output  32  number of mispredicted branches retired from D

## Operation
- Table: 2^INDEX_W entries of 2 bits, implemented in flops.
- Fetch-side read is combinational:
  - idxF = pcF[INDEX_W+1:2]
  - predF = pht[idxF][1]
- D-stage registers: pred_takeD and idxD.
  - rst or flushD: pred_takeD=0, idxD=0.
  - else if stallD: hold.
  - else: pred_takeD<=predF, idxD<=idxF.
- Update enable: upd = is_branchD & ~stallD & ~flushD & ~rst. A stalled branch trains exactly once, in the cycle it leaves D.
- Counter training on upd, entry pht[idxD]:
  - branch_takeD=1: increment, saturating at 2'b11.
  - branch_takeD=0: decrement, saturating at 2'b00.
  - 01+taken→10 and 10+not-taken→01, so direction flips after one miss from a weak state.
- Event counters on upd:
  - branch_cnt increments by 1.
  - mispred_cnt increments by 1 when mispredictD=1.
  - Both wrap modulo 2^32.
- Aliasing: PCs that share bits [INDEX_W+1:2] share an entry. There is no tag check.
- mispredictD is raw even while stallD=1. Consumers gate it with ~stallD before redirecting fetch.

## Timing
- Reset values:
  - every pht entry = INIT_CNT
  - pred_takeD=0, idxD=0
  - mispredictD=0 (follows is_branchD & pred_takeD != branch_takeD; is 0 while D holds a non-branch)
  - branch_cnt=0, mispred_cnt=0
- Prediction latency: pcF presented in cycle N yields pred_takeD in cycle N+1, provided stallD=0 and flushD=0 at the N edge.
- Training latency: the update written at the end of cycle N is visible to a fetch read in cycle N+1.
- Same-cycle read and write of the same index: the read returns the pre-update value (no bypass).
- Precedence: rst > flushD > stallD > normal. Reset in the middle of a stall or during training discards the pending update.
- flushD and stallD both high: the flush wins and no update occurs.

## Test plan
- Reset, pcF=0x0000_0040, next cycle is_branchD=1, branch_takeD=0 → pred_takeD=0, mispredictD=0; entry 16 goes 01→00; branch_cnt=1, mispred_cnt=0.
- Same PC, two consecutive taken resolutions → first: mispredictD=1, entry 01→10; re-fetch: pred_takeD=1; second taken: entry 10→11, mispredictD=0; mispred_cnt=1.
- Saturation: four taken resolutions on one entry → stays 11. Then one not-taken → 10, still predicts taken.
- Branch held in D with stallD=1 for 3 cycles, then released → counters and entry change exactly once; pred_takeD constant throughout.
- flushD=1 with is_branchD=1 → no table or counter update; pred_takeD=0 next cycle.
- pcF index equals idxD while a taken update from 01 is in flight → pred_takeD next cycle=0 (old value); the following fetch of that PC predicts 1.
